key_display_ctrl: RTL and testbench

KEY_DISPLAY_CTRL -- requirements
Module: key_display_ctrl

---
 rtl/key_display_ctrl.sv | 128 ++++++++++++
 tb/tb_key_display_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_display_ctrl.sv
//------------------------------------------------------------------------------
// key_display_ctrl : key-event FIFO feeding a two-digit multiplexed hex display
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_display_ctrl #(
  parameter int DWELL = 3000,
  parameter int BLANK = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic [1:0]               digit_sel,
  output logic [3:0]               seg_digit,
  output logic [3:0]               new_digit,
  output logic [3:0]               old_digit,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXN = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXN);

  typedef enum logic [1:0] {
    S_NEW     = 2'd0,
    S_BLANK_A = 2'd1,
    S_OLD     = 2'd2,
    S_BLANK_B = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   head_q, tail_q;
  logic [AW:0]     count_q;
  logic [3:0]      new_q, old_q;
  logic            ovf_q;

  logic            lit, last, pop, full, push, drop;

  always_comb begin
    lit  = (state_q == S_NEW) || (state_q == S_OLD);
    last = lit ? (cnt_q == CW'(DWELL - 1)) : (cnt_q == CW'(BLANK - 1));
    // Pops happen only on the first cycle of a blank window so a lit digit never changes.
    pop  = !lit && (cnt_q == '0) && (count_q != '0);
    full = (count_q == (AW+1)'(DEPTH));
    push = key_valid && (!full || pop);
    drop = key_valid && full && !pop;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (last) begin
      cnt_d = '0;
      unique case (state_q)
        S_NEW:     state_d = S_BLANK_A;
        S_BLANK_A: state_d = S_OLD;
        S_OLD:     state_d = S_BLANK_B;
        default:   state_d = S_NEW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NEW;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      new_q   <= '0;
      old_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        mem_q[tail_q] <= key_code;
        tail_q        <= tail_q + AW'(1);
      end
      if (pop) begin
        old_q  <= new_q;
        new_q  <= mem_q[head_q];
        head_q <= head_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    digit_sel = 2'b00;
    seg_digit = 4'h0;
    case (state_q)
      S_NEW: begin
        digit_sel = 2'b01;
        seg_digit = new_q;
      end
      S_OLD: begin
        digit_sel = 2'b10;
        seg_digit = old_q;
      end
      default: begin
        digit_sel = 2'b00;
        seg_digit = 4'h0;
      end
    endcase
  end

  assign new_digit  = new_q;
  assign old_digit  = old_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_key_display_ctrl.sv
//------------------------------------------------------------------------------
// tb_key_display_ctrl : scoreboard bench for key_display_ctrl (DWELL=4, BLANK=2)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_display_ctrl;

  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 2 * (DWELL + BLANK);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [1:0] digit_sel;
  logic [3:0] seg_digit, new_digit, old_digit;
  logic [2:0] fifo_count;
  logic       overflow;

  key_display_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .digit_sel  (digit_sel),
    .seg_digit  (seg_digit),
    .new_digit  (new_digit),
    .old_digit  (old_digit),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: refresh phase, queue occupancy and accepted keys awaiting display.
  int         phase = 0;
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;
  bit         pop_evt = 1'b0;
  bit         rst_evt = 1'b0;
  bit         mon_en = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] disp_new = 4'h0;
  logic [3:0] disp_old = 4'h0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      phase   = 0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      pop_evt = 1'b0;
      rst_evt = 1'b1;
      exp_q.delete();
    end else begin
      bit pop, full;
      pop  = ((phase == DWELL) || (phase == PERIOD - BLANK)) && (m_cnt > 0);
      full = (m_cnt == DEPTH);
      if (pop) begin
        m_cnt--;
        pop_evt = 1'b1;
      end
      if (key_valid) begin
        if (!full || pop) begin
          m_cnt++;
          exp_q.push_back(key_code);
        end else begin
          m_ovf = 1'b1;
        end
      end
      phase = (phase + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int exp_sel;
      if (rst_evt) begin
        rst_evt  = 1'b0;
        disp_new = 4'h0;
        disp_old = 4'h0;
      end
      if (pop_evt) begin
        pop_evt = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got display update expected none at %0t", $time);
        end else begin
          disp_old = disp_new;
          disp_new = exp_q.pop_front();
        end
      end
      if (phase < DWELL)               exp_sel = 1;
      else if (phase < DWELL + BLANK)  exp_sel = 0;
      else if (phase < PERIOD - BLANK) exp_sel = 2;
      else                             exp_sel = 0;
      chk("mon_digit_sel", digit_sel, exp_sel);
      chk("mon_seg_digit", seg_digit,
          (exp_sel == 1) ? disp_new : (exp_sel == 2) ? disp_old : 0);
      chk("mon_new_digit", new_digit, disp_new);
      chk("mon_old_digit", old_digit, disp_old);
      chk("mon_fifo_count", fifo_count, m_cnt);
      chk("mon_overflow", overflow, m_ovf);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_digit_sel", digit_sel, 1);
    chk("rst_seg_digit", seg_digit, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * PERIOD && phase != p; i++) @(negedge clk);
    if (phase != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: got phase %0d expected %0d", phase, p);
    end
  endtask

  task automatic pulse(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom);
  endtask

  initial begin
    @(negedge clk);
    mon_en = 1'b1;
    do_reset();

    // Idle refresh: two full periods, checked by the monitor.
    repeat (2 * PERIOD) @(negedge clk);

    // Single key on S_NEW cycle 0.
    do_reset();
    pulse(4'h5);
    for (int i = 0; i < 4; i++) begin
      chk("one_key_count", fifo_count, 1);
      @(negedge clk);
    end
    chk("one_key_new", new_digit, 5);
    chk("one_key_old", old_digit, 0);
    chk("one_key_drained", fifo_count, 0);
    @(negedge clk);
    chk("one_key_old_sel", digit_sel, 2);
    chk("one_key_old_seg", seg_digit, 0);

    // Five keys into a four-deep queue: key 5 is dropped.
    do_reset();
    wait_phase(PERIOD - 1);
    pulse(4'h1);
    pulse(4'h2);
    pulse(4'h3);
    pulse(4'h4);
    pulse(4'h5);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    wait_phase(PERIOD - 1);
    @(negedge clk);
    wait_phase(PERIOD - 1);
    chk("ovf_final_new", new_digit, 4);
    chk("ovf_final_old", old_digit, 3);
    chk("ovf_final_count", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);

    // Push while full on the same cycle as a pop is accepted.
    do_reset();
    pulse(4'h1);
    pulse(4'h2);
    pulse(4'h3);
    pulse(4'h4);
    wait_phase(6);
    pulse(4'h6);
    chk("full_setup_count", fifo_count, 4);
    wait_phase(PERIOD - BLANK);
    pulse(4'hA);
    chk("full_pp_count", fifo_count, 4);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_new", new_digit, 2);
    chk("full_pp_old", old_digit, 1);
    repeat (3 * PERIOD) @(negedge clk);
    chk("full_pp_drained", fifo_count, 0);

    // Reset mid-operation with keys queued and a simultaneous key.
    do_reset();
    pulse(4'h7);
    pulse(4'h8);
    pulse(4'h9);
    wait_phase(5);
    pulse(4'h1);
    wait_phase(7);
    chk("midrst_setup_count", fifo_count, 3);
    rst = 1'b1;
    key_valid = 1'b1;
    key_code = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b0;
    chk("midrst_sel", digit_sel, 1);
    chk("midrst_new", new_digit, 0);
    chk("midrst_old", old_digit, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ovf", overflow, 0);

    // Random key traffic, then drain.
    for (int i = 0; i < 3000; i++) begin
      key_valid = ($urandom_range(0, 5) == 0);
      key_code  = 4'($urandom);
      @(negedge clk);
    end
    key_valid = 1'b0;
    repeat (4 * PERIOD) @(negedge clk);
    chk("rand_drained_count", fifo_count, 0);
    chk("rand_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
